// File: rtl/comment_filter.sv
// Comment filter: replaces every character of a C line or block comment with REPL,
// delivering a one-character-per-clock stream delayed by exactly one cycle.
module comment_filter #(
    parameter logic [7:0] REPL = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic [7:0] out,
    output logic       comment
);

    typedef enum logic [2:0] {
        CODE,
        LINE,
        BLK_OPEN,
        BLK,
        BLK_STAR,
        BLK_END
    } cls_t;

    localparam logic [7:0] SLASH = 8'h2F;
    localparam logic [7:0] STAR  = 8'h2A;
    localparam logic [7:0] NL    = 8'h0A;

    logic [7:0] h;
    cls_t       hc;
    cls_t       cc;
    logic       sub;

    // Class of the incoming character, decided from the held character and its class.
    always_comb begin
        cc = CODE;
        case (hc)
            CODE: begin
                if (h == SLASH && in == SLASH)
                    cc = LINE;
                else if (h == SLASH && in == STAR)
                    cc = BLK_OPEN;
                else
                    cc = CODE;
            end
            LINE:     cc = (in == NL) ? CODE : LINE;
            BLK_OPEN,
            BLK:      cc = (in == STAR) ? BLK_STAR : BLK;
            BLK_STAR: begin
                if (in == SLASH)
                    cc = BLK_END;
                else if (in == STAR)
                    cc = BLK_STAR;
                else
                    cc = BLK;
            end
            BLK_END:  cc = CODE;
            default:  cc = CODE;
        endcase
    end

    // A held code slash is only substituted once its successor proves it opens a comment.
    always_comb begin
        sub = (hc != CODE) || (h == SLASH && (cc == LINE || cc == BLK_OPEN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= 8'h00;
            comment <= 1'b0;
            h       <= 8'h00;
            hc      <= CODE;
        end else begin
            out     <= sub ? REPL : h;
            comment <= sub;
            h       <= in;
            hc      <= cc;
        end
    end

endmodule

// File: tb/tb_comment_filter.sv
// Scoreboard bench for comment_filter: directed and random character segments, each
// masked by a whole-string comment scanner and compared cycle by cycle against the DUT.
module tb_comment_filter;

    localparam logic [7:0] REPL = 8'h20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in;
    logic [7:0] out;
    logic       comment;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    logic [7:0] seg[$];
    logic       mask[$];

    comment_filter #(.REPL(REPL)) dut (
        .clk(clk),
        .reset(reset),
        .in(in),
        .out(out),
        .comment(comment)
    );

    always #5 clk = ~clk;

    // Monitor: compares each presented output against the oldest pending expectation.
    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({comment, out} !== e) begin
                errors++;
                $display("FAIL stream t=%0t: got out=%02h comment=%0b, want out=%02h comment=%0b",
                         $time, out, comment, e[7:0], e[8]);
            end
        end
    end

    // Reference: scan the whole segment as text and mark every character inside a comment.
    function automatic void scan();
        int n;
        int i;
        int j;
        bit closed;
        n = seg.size();
        mask = {};
        for (int k = 0; k < n; k++) mask.push_back(1'b0);
        i = 0;
        while (i < n) begin
            if (seg[i] == "/" && i + 1 < n && seg[i+1] == "/") begin
                j = i;
                while (j < n && seg[j] != 8'h0A) begin
                    mask[j] = 1'b1;
                    j++;
                end
                i = j;
            end else if (seg[i] == "/" && i + 1 < n && seg[i+1] == "*") begin
                mask[i] = 1'b1;
                mask[i+1] = 1'b1;
                j = i + 2;
                closed = 0;
                while (j < n && !closed) begin
                    mask[j] = 1'b1;
                    if (seg[j] == "*" && j + 1 < n && seg[j+1] == "/") begin
                        mask[j+1] = 1'b1;
                        closed = 1;
                    end else begin
                        j++;
                    end
                end
                i = closed ? j + 2 : n;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic drive(input logic r, input logic [7:0] c, input logic [8:0] e);
        @(negedge clk);
        reset = r;
        in    = c;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    // One reset cycle, then the segment; output k+1 is character k, filtered.
    task automatic run_seg();
        logic [8:0] e;
        scan();
        drive(1'b1, 8'h00, 9'h000);
        for (int k = 0; k < seg.size(); k++) begin
            if (k == 0)
                e = 9'h000;
            else if (mask[k-1])
                e = {1'b1, REPL};
            else
                e = {1'b0, seg[k-1]};
            drive(1'b0, seg[k], e);
        end
    endtask

    task automatic set_seg(input string s, input bit tail_nul);
        seg = {};
        for (int k = 0; k < s.len(); k++) seg.push_back(s[k]);
        if (tail_nul) seg.push_back(8'h00);
    endtask

    initial begin
        int len;
        int pick;
        int waited;
        reset = 1'b1;
        in    = 8'h00;

        set_seg("a/bc", 0);          run_seg();
        seg = {8'h78, 8'h2F, 8'h2F, 8'h61, 8'h62, 8'h0A, 8'h79, 8'h00};
        run_seg();
        set_seg("i/*/n*/t", 1);      run_seg();
        set_seg("a/***//b", 1);      run_seg();
        set_seg("/*q", 0);           run_seg();
        set_seg("/x", 1);            run_seg();
        seg = {8'h09, 8'h2F, 8'h09, 8'h2F, 8'h2F, 8'h2A, 8'h2A, 8'h2F, 8'h78, 8'h00};
        run_seg();

        for (int r = 0; r < 40; r++) begin
            seg = {};
            len = $urandom_range(3, 40);
            for (int k = 0; k < len; k++) begin
                pick = $urandom_range(0, 9);
                case (pick)
                    0, 1, 2: seg.push_back(8'h2F);
                    3, 4:    seg.push_back(8'h2A);
                    5:       seg.push_back(8'h0A);
                    6:       seg.push_back(8'h00);
                    default: seg.push_back(8'($urandom_range(8'h21, 8'h7E)));
                endcase
            end
            run_seg();
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comment_filter.md
Name: comment_filter

Overview:
- Character-stream pre-stage that sits directly upstream of the declaration checker. It takes one ASCII character per clock.
- It replaces every character belonging to a C comment (`//...` line comment or `/*...*/` block comment, delimiters included) with a replacement character. All other characters pass through unchanged.
- The output stream keeps one character per clock with a fixed one-cycle delay, so it drops straight into the checker's `in` port.

Parameters:
- REPL, 8'h20, replacement character emitted for comment characters (ASCII space).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in  input  8  ASCII character sampled every rising edge (no valid strobe; every cycle is a character)
- out  output  8  filtered character stream, registered
- comment  output  1  registered; 1 when the current `out` value was substituted by REPL

Behaviour:
- One clock; reset is synchronous and active-high (`reset` sampled on rising edge of `clk`).
- Internal state:
  - hold register `h` (8b): last sampled character.
  - class register `hc` of `h`: CODE, LINE, BLK_OPEN, BLK, BLK_STAR, BLK_END.
- Reset values: `out`=8'h00, `comment`=0, `h`=8'h00, `hc`=CODE. Reset mid-comment abandons the comment; the first post-reset character is classified from CODE.
- Each rising edge (reset low), with new input `c`:
  - compute class `cc` of `c` from (`hc`, `h`, `c`).
  - emit `h`.
  - then `h`<=`c`, `hc`<=`cc`.
- Class transitions (`cc`):
  - CODE: `h`=="/" and `c`=="/" -> LINE; `h`=="/" and `c`=="*" -> BLK_OPEN; else CODE.
  - LINE: `c`==8'h0A -> CODE (newline is code, passes unchanged); else LINE.
  - BLK_OPEN or BLK: `c`=="*" -> BLK_STAR; else BLK. The opening star never closes, so `/*/` does not terminate.
  - BLK_STAR: `c`=="/" -> BLK_END; `c`=="*" -> BLK_STAR; else BLK.
  - BLK_END: -> CODE, regardless of `c`. A "/" right after `*/` is code and may open a new comment.
- Emission:
  - `sub` = (`hc`!=CODE) or (`h`=="/" and `cc` in {LINE, BLK_OPEN}).
  - `out`<= `sub` ? REPL : `h`; `comment`<=`sub`.
- Latency:
  - A character sampled at edge k appears on `out` after edge k+1.
  - The first cycle after reset release shows 8'h00 (the reset value of `h`).
- A code "/" is held one cycle until its successor decides its fate; it is never emitted early.
- Unterminated comments persist indefinitely; there is no timeout and no error output.
- All other bytes, including tab 8'h09 and 8'h00, are ordinary characters.
- Comparisons are exact 8-bit equality; no case folding.

Test Plan:
- Pass-through:
  - Stimulus: reset 1 cycle, then "a","/","b","c".
  - Required `out` after successive edges: 8'h00, "a", "/", "b"; `comment` always 0.
- Line comment:
  - Stimulus: "x","/","/","a","b",8'h0A,"y",8'h00.
  - Required `out`: "x", 4×8'h20, 8'h0A, "y".
  - Required `comment`: 0, 1,1,1,1, 0, 0.
- Block comment with `/*/` trap:
  - Stimulus: "i","/","*","/","n","*","/","t",8'h00.
  - Required `out`: "i", 6×8'h20, "t".
- Stars and adjacency:
  - Stimulus: "a","/","*","*","*","/","/","b",8'h00.
  - Required `out`: "a", 5×8'h20, "/", "b". Here `***/` closes the comment and the following "/" is code.
- Reset mid-comment:
  - Stimulus: "/","*","q", then reset 1 cycle, then "/","x",8'h00.
  - Required: `out`=8'h00 and `comment`=0 after the reset edge, then `out` = 8'h00, "/", "x".
